// File: rtl/spi_wrapper.sv
// SPI slave decoding 10-bit frames into commands for a 256x8 RAM, read data returned on MISO.
// Optional: define SPI_MISO_HIZ_EN to tristate MISO outside the output phase instead of driving 0.
module spi_ram #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] din_i,
   input  logic       rx_valid_i,
   output logic [7:0] dout_o,
   output logic       tx_valid_o
);
   logic [7:0]           mem [0:MEM_DEPTH-1];
   logic [ADDR_SIZE-1:0] wr_addr_q;
   logic [ADDR_SIZE-1:0] rd_addr_q;
   logic [7:0]           dout_q;
   logic                 tx_valid_q;

   // The array carries no reset so a preload survives rst_n.
   always_ff @(posedge clk) begin
      if (rx_valid_i && din_i[9:8] == 2'b01) begin
         mem[wr_addr_q] <= din_i[7:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr_q  <= '0;
         rd_addr_q  <= '0;
         dout_q     <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         tx_valid_q <= 1'b0;
         if (rx_valid_i) begin
            case (din_i[9:8])
               2'b00:   wr_addr_q <= din_i[ADDR_SIZE-1:0];
               2'b10:   rd_addr_q <= din_i[ADDR_SIZE-1:0];
               2'b11: begin
                  dout_q     <= mem[rd_addr_q];
                  tx_valid_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign dout_o     = dout_q;
   assign tx_valid_o = tx_valid_q;
endmodule

module spi_wrapper #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       MOSI,
   input  logic       SS_n,
   output logic       MISO,
   output logic [2:0] state_dbg_o,
   output logic       rd_addr_flag_o
);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CHK_CMD   = 3'd1;
   localparam logic [2:0] WRITE     = 3'd2;
   localparam logic [2:0] READ_ADD  = 3'd3;
   localparam logic [2:0] READ_DATA = 3'd4;

   logic [2:0] state_q, state_d;
   logic [3:0] bit_cnt_q;
   logic [9:0] rx_data_q;
   logic       rx_valid_q;
   logic       rd_addr_flag_q;
   logic [7:0] tx_shift_q;
   logic [2:0] out_cnt_q;
   logic       out_active_q;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       in_data_state;

   always_comb begin
      state_d = state_q;
      if (SS_n) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = CHK_CMD;
            CHK_CMD: state_d = !MOSI ? WRITE : (rd_addr_flag_q ? READ_DATA : READ_ADD);
            default: state_d = state_q;
         endcase
      end
   end

   assign in_data_state = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         rx_data_q      <= '0;
         rx_valid_q     <= 1'b0;
         rd_addr_flag_q <= 1'b0;
         tx_shift_q     <= '0;
         out_cnt_q      <= '0;
         out_active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_valid_q <= 1'b0;
         if (SS_n) begin
            bit_cnt_q    <= '0;
            out_active_q <= 1'b0;
         end else if (in_data_state) begin
            // After the 10th bit the frame is held until SS_n rises; extra MOSI bits are ignored.
            if (bit_cnt_q != 4'd10) begin
               rx_data_q <= {rx_data_q[8:0], MOSI};
               bit_cnt_q <= bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd9) begin
                  rx_valid_q <= 1'b1;
                  if (state_q == READ_ADD)  rd_addr_flag_q <= 1'b1;
                  if (state_q == READ_DATA) rd_addr_flag_q <= 1'b0;
               end
            end
            if (state_q == READ_DATA && tx_valid) begin
               tx_shift_q   <= tx_data;
               out_cnt_q    <= '0;
               out_active_q <= 1'b1;
            end else if (out_active_q) begin
               tx_shift_q <= {tx_shift_q[6:0], 1'b0};
               out_cnt_q  <= out_cnt_q + 3'd1;
               if (out_cnt_q == 3'd7) out_active_q <= 1'b0;
            end
         end
      end
   end

   spi_ram #(
      .MEM_DEPTH(MEM_DEPTH),
      .ADDR_SIZE(ADDR_SIZE)
   ) RAMblock (
      .clk       (clk),
      .rst_n     (rst_n),
      .din_i     (rx_data_q),
      .rx_valid_i(rx_valid_q),
      .dout_o    (tx_data),
      .tx_valid_o(tx_valid)
   );

`ifdef SPI_MISO_HIZ_EN
   assign MISO = (!SS_n && out_active_q) ? tx_shift_q[7] : 1'bz;
`else
   assign MISO = (!SS_n && out_active_q) ? tx_shift_q[7] : 1'b0;
`endif

   assign state_dbg_o    = state_q;
   assign rd_addr_flag_o = rd_addr_flag_q;
endmodule

// File: tb/tb_spi_wrapper.sv
// Randomized frame-level bench for spi_wrapper against a transaction-level memory/command model.
module tb_spi_wrapper;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       MOSI;
  logic       SS_n;
  logic       MISO;
  logic [2:0] state_dbg;
  logic       rd_flag;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_mem [256];
  logic [7:0] m_wa;
  logic [7:0] m_ra;
  logic       m_flag;
  logic [0:0] exp_q [$];
  logic [7:0] last_miso;

  spi_wrapper dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .MOSI          (MOSI),
    .SS_n          (SS_n),
    .MISO          (MISO),
    .state_dbg_o   (state_dbg),
    .rd_addr_flag_o(rd_flag)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic ss, input logic mosi);
    @(negedge clk);
    SS_n = ss;
    MOSI = mosi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_miso", MISO, 0);
    check("rst_state", state_dbg, 0);
    check("rst_flag", rd_flag, 0);
    check("rst_wr_addr", dut.RAMblock.wr_addr_q, 0);
    check("rst_rd_addr", dut.RAMblock.rd_addr_q, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_wa   = 8'h00;
    m_ra   = 8'h00;
    m_flag = 1'b0;
  endtask

  // One frame: cmd bit, 10 data bits (only nbits sent before an abort), then hold cycles with SS_n low.
  task automatic frame(input logic cmd, input logic [9:0] data, input int nbits, input int hold);
    logic       path_rd;
    logic       sends;
    logic [7:0] exp_byte;
    logic [0:0] eb;
    cyc(1'b0, 1'b0);
    cyc(1'b0, cmd);
    for (int i = 0; i < nbits; i++) begin
      cyc(1'b0, data[9-i]);
      check("miso_rx_phase", MISO, 0);
    end
    if (nbits < 10) begin
      cyc(1'b1, 1'b0);
      check("abort_miso", MISO, 0);
      check("abort_state", state_dbg, 0);
      check("abort_flag", rd_flag, m_flag);
      return;
    end
    path_rd  = cmd & m_flag;
    if (cmd) m_flag = ~m_flag;
    sends    = 1'b0;
    exp_byte = 8'h00;
    case (data[9:8])
      2'b00: m_wa = data[7:0];
      2'b01: m_mem[m_wa] = data[7:0];
      2'b10: m_ra = data[7:0];
      default: begin
        exp_byte = m_mem[m_ra];
        sends    = path_rd;
      end
    endcase
    if (hold > 0) begin
      exp_q.push_back(1'b0);
      for (int b = 7; b >= 0; b--) exp_q.push_back(sends ? exp_byte[b] : 1'b0);
    end
    last_miso = 8'h00;
    for (int h = 0; h < hold; h++) begin
      cyc(1'b0, 1'($urandom_range(0, 1)));
      eb = exp_q.pop_front();
      check("miso_tx", MISO, eb);
      if (h > 0) last_miso = {last_miso[6:0], MISO};
      if (h == 0 && data[9:8] == 2'b11) check("dout", dut.RAMblock.dout_q, exp_byte);
    end
    cyc(1'b1, 1'b0);
    check("end_miso", MISO, 0);
    check("end_state", state_dbg, 0);
    check("end_flag", rd_flag, m_flag);
  endtask

  initial begin
    logic [7:0] adr [3];
    logic [7:0] dat [3];
    logic       c;
    int         nb;
    adr[0] = 8'h1c; adr[1] = 8'h7c; adr[2] = 8'h62;
    dat[0] = 8'haf; dat[1] = 8'he9; dat[2] = 8'hca;
    rst_n = 1'b1;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = 8'($urandom_range(0, 255));
      dut.RAMblock.mem[i] = m_mem[i];
    end
    do_reset();
    for (int i = 0; i < 8; i++) begin
      nb = $urandom_range(0, 255);
      check("preload_kept", dut.RAMblock.mem[nb], m_mem[nb]);
    end

    for (int k = 0; k < 3; k++) begin
      frame(1'b0, {2'b00, adr[k]}, 10, 9);
      frame(1'b0, {2'b01, dat[k]}, 10, 9);
      frame(1'b1, {2'b10, adr[k]}, 10, 9);
      frame(1'b1, {2'b11, 8'($urandom_range(0, 255))}, 10, 9);
      check("miso_byte", last_miso, dat[k]);
    end
    check("mem_1c", dut.RAMblock.mem[8'h1c], 8'haf);
    check("mem_7c", dut.RAMblock.mem[8'h7c], 8'he9);
    check("mem_62", dut.RAMblock.mem[8'h62], 8'hca);

    frame(1'b0, {2'b01, 8'h55}, 5, 0);
    check("abort_wr_addr", dut.RAMblock.wr_addr_q, m_wa);
    check("abort_mem", dut.RAMblock.mem[m_wa], m_mem[m_wa]);
    frame(1'b0, {2'b01, 8'h3d}, 10, 0);
    check("post_abort_mem", dut.RAMblock.mem[m_wa], 8'h3d);

    do_reset();
    frame(1'b1, {2'b11, 8'ha5}, 10, 9);
    check("rd_no_addr_flag", rd_flag, 1);
    check("rd_no_addr_miso", last_miso, 8'h00);

    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    do_reset();
    check("midreset_mem", dut.RAMblock.mem[8'h1c], m_mem[8'h1c]);

    for (int n = 0; n < 300; n++) begin
      c  = 1'($urandom_range(0, 1));
      nb = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 9) : 10;
      frame(c, 10'($urandom_range(0, 1023)), nb, (c || $urandom_range(0, 1) == 1) ? 9 : 0);
    end

    for (int i = 0; i < 256; i++) check("final_mem", dut.RAMblock.mem[i], m_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
